// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   Bundles every signal of one pipeline boundary except clock and reset:
//   the stage controls (en, flush), the incoming slot (*_i), the
//   write-back refresh source (wb_*) and the registered slot (*_n).
//
//   Modports:
//     master - upstream/hazard side: drives en, flush, *_i, wb_*; reads *_n
//     slave  - the pipeline register itself: reads en, flush, *_i, wb_*;
//              drives *_n
//
//   Handshake: there is no valid/ready pair at this boundary. en advances
//   the slot on a rising edge, flush turns it into a bubble and wins over
//   en. valid_i/valid_n only tag whether the slot holds a real
//   instruction; they never gate loading.
//
//   Parameters: DW operand/result width, AW register-index width,
//   TW hazard-counter width.
interface pipe_stage_reg_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int TW = 2
);
  logic          en;
  logic          flush;

  logic          valid_i;
  logic [31:0]   ins_i;
  logic [31:0]   pc_i;
  logic [AW-1:0] a3_i;
  logic [TW-1:0] tuse_rs_i;
  logic [TW-1:0] tuse_rt_i;
  logic [TW-1:0] tnew_i;
  logic [DW-1:0] rd1_i;
  logic [DW-1:0] rd2_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] alu_i;

  logic          wb_we;
  logic [AW-1:0] wb_a3;
  logic [DW-1:0] wb_wd;

  logic          valid_n;
  logic [31:0]   ins_n;
  logic [31:0]   pc_n;
  logic [AW-1:0] a3_n;
  logic [TW-1:0] tuse_rs_n;
  logic [TW-1:0] tuse_rt_n;
  logic [TW-1:0] tnew_n;
  logic [DW-1:0] rd1_n;
  logic [DW-1:0] rd2_n;
  logic [DW-1:0] data_n;
  logic [DW-1:0] alu_n;

  modport master (
    output en, flush,
    output valid_i, ins_i, pc_i, a3_i, tuse_rs_i, tuse_rt_i, tnew_i,
    output rd1_i, rd2_i, data_i, alu_i,
    output wb_we, wb_a3, wb_wd,
    input  valid_n, ins_n, pc_n, a3_n, tuse_rs_n, tuse_rt_n, tnew_n,
    input  rd1_n, rd2_n, data_n, alu_n
  );

  modport slave (
    input  en, flush,
    input  valid_i, ins_i, pc_i, a3_i, tuse_rs_i, tuse_rt_i, tnew_i,
    input  rd1_i, rd2_i, data_i, alu_i,
    input  wb_we, wb_a3, wb_wd,
    output valid_n, ins_n, pc_n, a3_n, tuse_rs_n, tuse_rt_n, tnew_n,
    output rd1_n, rd2_n, data_n, alu_n
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register of the five-stage MIPS core (D/E/M/W).
//   Carries instruction, PC, destination register, Tuse/Tnew hazard
//   counters, two operands and two result words to the next stage.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-low; forces the bubble value
//     bus    - pipe_stage_reg_if.slave (en, flush, *_i, wb_*, *_n)
//
//   Per-edge priority: reset > flush > en > hold.
//   Bubble: valid=0, ins/pc/a3=0, tuse_rs/tuse_rt all-ones (no use),
//   tnew=0, operands/results 0.
//   Load: plain fields copy; each counter loads max(c_i - DEC, 0).
//
//   Optional feature, macro PIPE_STAGE_REG_REFRESH_EN:
//     while holding a valid slot, a write-back to rs/rt (index != 0)
//     replaces the held rd1/rd2 so a stalled instruction does not keep a
//     stale operand. Without the macro the wb_* inputs are ignored.
module pipe_stage_reg #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int TW  = 2,
  parameter int DEC = 1
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  localparam logic [TW-1:0] DEC_T = TW'(DEC);

  // Saturating decrement: never wraps below zero to all-ones.
  function automatic logic [TW-1:0] sat(input logic [TW-1:0] c);
    logic [TW-1:0] r;
    if (c < DEC_T) r = '0;
    else           r = c - DEC_T;
    return r;
  endfunction

  logic          valid_q;
  logic [31:0]   ins_q;
  logic [31:0]   pc_q;
  logic [AW-1:0] a3_q;
  logic [TW-1:0] tuse_rs_q;
  logic [TW-1:0] tuse_rt_q;
  logic [TW-1:0] tnew_q;
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] alu_q;

  // Refresh hits for the held slot; constant 0 when the feature is off.
  logic hit_rs;
  logic hit_rt;

`ifdef PIPE_STAGE_REG_REFRESH_EN
  logic [AW-1:0] rs_idx;
  logic [AW-1:0] rt_idx;
  logic          wb_live;

  assign rs_idx  = AW'(ins_q[25:21]);
  assign rt_idx  = AW'(ins_q[20:16]);
  // Register 0 is never a real write-back target.
  assign wb_live = valid_q && bus.wb_we && (bus.wb_a3 != '0);
  assign hit_rs  = wb_live && (bus.wb_a3 == rs_idx);
  assign hit_rt  = wb_live && (bus.wb_a3 == rt_idx);
`else
  assign hit_rs  = 1'b0;
  assign hit_rt  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      ins_q     <= '0;
      pc_q      <= '0;
      a3_q      <= '0;
      tuse_rs_q <= '1;
      tuse_rt_q <= '1;
      tnew_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      data_q    <= '0;
      alu_q     <= '0;
    end else if (bus.flush) begin
      valid_q   <= 1'b0;
      ins_q     <= '0;
      pc_q      <= '0;
      a3_q      <= '0;
      tuse_rs_q <= '1;
      tuse_rt_q <= '1;
      tnew_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      data_q    <= '0;
      alu_q     <= '0;
    end else if (bus.en) begin
      valid_q   <= bus.valid_i;
      ins_q     <= bus.ins_i;
      pc_q      <= bus.pc_i;
      a3_q      <= bus.a3_i;
      tuse_rs_q <= sat(bus.tuse_rs_i);
      tuse_rt_q <= sat(bus.tuse_rt_i);
      tnew_q    <= sat(bus.tnew_i);
      rd1_q     <= bus.rd1_i;
      rd2_q     <= bus.rd2_i;
      data_q    <= bus.data_i;
      alu_q     <= bus.alu_i;
    end else begin
      // Hold; only the operands may be refreshed from write-back.
      if (hit_rs) rd1_q <= bus.wb_wd;
      if (hit_rt) rd2_q <= bus.wb_wd;
    end
  end

  assign bus.valid_n   = valid_q;
  assign bus.ins_n     = ins_q;
  assign bus.pc_n      = pc_q;
  assign bus.a3_n      = a3_q;
  assign bus.tuse_rs_n = tuse_rs_q;
  assign bus.tuse_rt_n = tuse_rt_q;
  assign bus.tnew_n    = tnew_q;
  assign bus.rd1_n     = rd1_q;
  assign bus.rd2_n     = rd2_q;
  assign bus.data_n    = data_q;
  assign bus.alu_n     = alu_q;

endmodule
